// File: rtl/memory_access_unit.sv
// Initiator for the bsm1e data-memory port: one load/store at a time, misaligned
// word accesses split into two byte accesses, out-of-range addresses flagged.
module memory_access_unit #(
  parameter int unsigned MEM_BYTES   = 8,
  parameter bit          SIGN_EXTEND = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] req_address,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_write,
  output logic        mem_select_byte,
  output logic [15:0] mem_address,
  output logic [15:0] mem_input_data,
  input  logic [15:0] mem_output_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [16:0] MEM_LIMIT = 17'(MEM_BYTES);

  // A misaligned word also touches A+1, which may wrap past 0xFFFF.
  function automatic logic range_err(input logic [15:0] a, input logic mis);
    logic [15:0] a_next;
    a_next = a + 16'd1;
    return ({1'b0, a} >= MEM_LIMIT) | (mis & ({1'b0, a_next} >= MEM_LIMIT));
  endfunction

  function automatic logic [15:0] load_result(input logic wr, input logic byte_acc,
                                              input logic err, input logic [7:0] lo,
                                              input logic [7:0] hi);
    if (wr || err) begin
      return 16'h0000;
    end else if (byte_acc) begin
      return {{8{lo[7] & SIGN_EXTEND}}, lo};
    end else begin
      return {hi, lo};
    end
  endfunction

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic        byte_q, byte_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_sel_q, mem_sel_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [15:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;

  logic handshake_s;
  logic mis_in_s;
  logic mis_q_s;

  assign req_ready   = (state_q == IDLE) & ~reset;
  assign handshake_s = req_valid & req_ready;
  assign mis_in_s    = ~req_byte & req_address[0];
  assign mis_q_s     = ~byte_q & addr_q[0];

  // Next-state and next-output logic; outputs for a state are prepared on entry.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    byte_d       = byte_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    mem_write_d  = 1'b0;
    mem_sel_d    = 1'b0;
    mem_addr_d   = 16'h0000;
    mem_wdata_d  = 16'h0000;
    resp_valid_d = 1'b0;
    resp_rdata_d = 16'h0000;
    resp_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (handshake_s) begin
          write_d     = req_write;
          byte_d      = req_byte;
          addr_d      = req_address;
          wdata_d     = req_wdata;
          err_d       = range_err(req_address, mis_in_s);
          state_d     = FIRST;
          mem_addr_d  = req_address;
          mem_sel_d   = req_byte | mis_in_s;
          mem_wdata_d = mis_in_s ? {8'h00, req_wdata[7:0]} : req_wdata;
          mem_write_d = req_write & ~err_d;
        end else begin
          state_d = IDLE;
        end
      end
      FIRST: begin
        lo_d = addr_q[0] ? mem_output_data[15:8] : mem_output_data[7:0];
        hi_d = mem_output_data[15:8];
        if (mis_q_s & ~err_q) begin
          state_d     = SECOND;
          mem_addr_d  = addr_q + 16'd1;
          mem_sel_d   = 1'b1;
          mem_wdata_d = {8'h00, wdata_q[15:8]};
          mem_write_d = write_q;
        end else begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_result(write_q, byte_q, err_q, lo_d, hi_d);
          resp_error_d = err_q;
        end
      end
      SECOND: begin
        hi_d         = mem_output_data[7:0];
        state_d      = DONE;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_result(write_q, byte_q, err_q, lo_q, hi_d);
        resp_error_d = err_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      byte_q       <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      err_q        <= 1'b0;
      lo_q         <= 8'h00;
      hi_q         <= 8'h00;
      mem_write_q  <= 1'b0;
      mem_sel_q    <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 16'h0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 16'h0000;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      byte_q       <= byte_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      mem_write_q  <= mem_write_d;
      mem_sel_q    <= mem_sel_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Reset forces the pins low within its own cycle so an abandoned store cannot land.
  assign mem_write       = mem_write_q & ~reset;
  assign mem_select_byte = mem_sel_q & ~reset;
  assign mem_address     = mem_addr_q & {16{~reset}};
  assign mem_input_data  = mem_wdata_q & {16{~reset}};
  assign resp_valid      = resp_valid_q & ~reset;
  assign resp_rdata      = resp_rdata_q & {16{~reset}};
  assign resp_error      = resp_error_q & ~reset;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with an 8-byte memory model attached;
// a second instance with SIGN_EXTEND=1 shadows the same stimulus for byte loads.
module tb_memory_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_byte;
  logic [15:0] req_address, req_wdata;
  logic        req_ready, resp_valid, resp_error;
  logic [15:0] resp_rdata;
  logic        mem_write, mem_select_byte;
  logic [15:0] mem_address, mem_input_data, mem_output_data;
  logic        req_ready_se, resp_valid_se, resp_error_se;
  logic [15:0] resp_rdata_se;
  logic        mem_write_se, mem_select_byte_se;
  logic [15:0] mem_address_se, mem_input_data_se, mem_output_data_se;

  logic [7:0]  mem [0:7];
  logic [7:0]  init_bytes [0:7] = '{8'h01, 8'hFE, 8'h80, 8'h01, 8'h01, 8'h01, 8'h81, 8'h01};
  logic        mem_load;

  int errors = 0;
  int checks = 0;
  int lat, wcnt;
  logic [15:0] rd, rdse;
  logic        er;

  always #5 clock = ~clock;

  memory_access_unit #(.MEM_BYTES(8), .SIGN_EXTEND(1'b0)) u_dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_byte(req_byte), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_write(mem_write), .mem_select_byte(mem_select_byte),
    .mem_address(mem_address), .mem_input_data(mem_input_data),
    .mem_output_data(mem_output_data)
  );

  memory_access_unit #(.MEM_BYTES(8), .SIGN_EXTEND(1'b1)) u_dut_se (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_se),
    .req_write(req_write), .req_byte(req_byte), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(resp_valid_se), .resp_rdata(resp_rdata_se),
    .resp_error(resp_error_se), .mem_write(mem_write_se),
    .mem_select_byte(mem_select_byte_se), .mem_address(mem_address_se),
    .mem_input_data(mem_input_data_se), .mem_output_data(mem_output_data_se)
  );

  // memory_unit model: synchronous write, combinational aligned-word read
  always @(posedge clock) begin
    if (mem_load) begin
      for (int i = 0; i < 8; i++) mem[i] <= init_bytes[i];
    end else if (mem_write && mem_address < 16'd8) begin
      if (mem_select_byte) begin
        mem[mem_address[2:0]] <= mem_input_data[7:0];
      end else begin
        mem[{mem_address[2:1], 1'b0}] <= mem_input_data[7:0];
        mem[{mem_address[2:1], 1'b1}] <= mem_input_data[15:8];
      end
    end
  end

  assign mem_output_data = (mem_address < 16'd8) ?
      {mem[{mem_address[2:1], 1'b1}], mem[{mem_address[2:1], 1'b0}]} : 16'h0000;
  assign mem_output_data_se = (mem_address_se < 16'd8) ?
      {mem[{mem_address_se[2:1], 1'b1}], mem[{mem_address_se[2:1], 1'b0}]} : 16'h0000;

  task automatic issue(input logic wr, input logic bt, input logic [15:0] addr,
                       input logic [15:0] wd);
    int n;
    n = 0;
    req_write = wr; req_byte = bt; req_address = addr; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: req_ready=%0b required 1", req_ready);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0; req_write = ~wr; req_byte = ~bt;
    req_address = addr ^ 16'h0005; req_wdata = ~wd;
    lat = 0; wcnt = 0; rd = 16'h0000; rdse = 16'h0000; er = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (mem_write) wcnt++;
      if (resp_valid) begin
        lat = k; rd = resp_rdata; rdse = resp_rdata_se; er = resp_error;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_load = 1'b1; req_valid = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    mem_load = 1'b0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b required 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %0b required 0", resp_valid); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %0b required 0", mem_write); end
    checks++; if (mem_address !== 16'h0000) begin errors++; $display("FAIL reset_mem_address: got %h required 0000", mem_address); end
    checks++; if (resp_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h required 0000", resp_rdata); end
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b required 1", req_ready); end
  endtask

  task automatic test_word_load();
    issue(1'b0, 1'b0, 16'h0000, 16'h0000);
    checks++; if (lat !== 2) begin errors++; $display("FAIL word_load_latency: got %0d required 2", lat); end
    checks++; if (rd !== 16'hFE01) begin errors++; $display("FAIL word_load_rdata: got %h required FE01", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL word_load_error: got %0b required 0", er); end
  endtask

  task automatic test_byte_load();
    issue(1'b0, 1'b1, 16'h0001, 16'h0000);
    checks++; if (lat !== 2) begin errors++; $display("FAIL byte_load_latency: got %0d required 2", lat); end
    checks++; if (rd !== 16'h00FE) begin errors++; $display("FAIL byte_load_zext: got %h required 00FE", rd); end
    checks++; if (rdse !== 16'hFFFE) begin errors++; $display("FAIL byte_load_sext: got %h required FFFE", rdse); end
    issue(1'b0, 1'b1, 16'h0002, 16'h0000);
    checks++; if (rd !== 16'h0080) begin errors++; $display("FAIL byte_load2_zext: got %h required 0080", rd); end
    checks++; if (rdse !== 16'hFF80) begin errors++; $display("FAIL byte_load2_sext: got %h required FF80", rdse); end
    issue(1'b0, 1'b1, 16'h0003, 16'h0000);
    checks++; if (rdse !== 16'h0001) begin errors++; $display("FAIL byte_load3_sext: got %h required 0001", rdse); end
  endtask

  task automatic test_misaligned_load();
    issue(1'b0, 1'b0, 16'h0001, 16'h0000);
    checks++; if (lat !== 3) begin errors++; $display("FAIL mis_load_latency: got %0d required 3", lat); end
    checks++; if (rd !== 16'h80FE) begin errors++; $display("FAIL mis_load_rdata: got %h required 80FE", rd); end
    @(negedge clock);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_pulse_width: got %0b required 0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_done: got %0b required 1", req_ready); end
  endtask

  task automatic test_reset_mid();
    int seen;
    req_write = 1'b1; req_byte = 1'b0; req_address = 16'h0001; req_wdata = 16'h1234;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mid_mem_write: got %0b required 0", mem_write); end
    @(posedge clock); #1;
    reset = 1'b0;
    seen = 0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %0b required 1", req_ready); end
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) seen++;
      @(negedge clock);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_resp: got %0d pulses required 0", seen); end
    checks++; if (mem[1] !== 8'h34) begin errors++; $display("FAIL reset_mid_byte1: got %h required 34", mem[1]); end
    checks++; if (mem[2] !== 8'h80) begin errors++; $display("FAIL reset_mid_byte2: got %h required 80", mem[2]); end
  endtask

  task automatic test_misaligned_store();
    issue(1'b1, 1'b0, 16'h0003, 16'hBEEF);
    checks++; if (lat !== 3) begin errors++; $display("FAIL mis_store_latency: got %0d required 3", lat); end
    checks++; if (wcnt !== 2) begin errors++; $display("FAIL mis_store_writes: got %0d required 2", wcnt); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL mis_store_rdata: got %h required 0000", rd); end
    issue(1'b0, 1'b0, 16'h0002, 16'h0000);
    checks++; if (rd !== 16'hEF80) begin errors++; $display("FAIL mis_store_check2: got %h required EF80", rd); end
    issue(1'b0, 1'b0, 16'h0004, 16'h0000);
    checks++; if (rd !== 16'h01BE) begin errors++; $display("FAIL mis_store_check4: got %h required 01BE", rd); end
  endtask

  task automatic test_errors();
    logic [7:0] exp_bytes [0:7] = '{8'h01, 8'h34, 8'h80, 8'hEF, 8'hBE, 8'h01, 8'h81, 8'h01};
    issue(1'b0, 1'b0, 16'h0007, 16'h0000);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_load7_error: got %0b required 1", er); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL err_load7_rdata: got %h required 0000", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL err_load7_latency: got %0d required 2", lat); end
    issue(1'b1, 1'b1, 16'h0008, 16'h00AA);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_store8_error: got %0b required 1", er); end
    checks++; if (wcnt !== 0) begin errors++; $display("FAIL err_store8_writes: got %0d required 0", wcnt); end
    issue(1'b1, 1'b0, 16'h0007, 16'hCAFE);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_store7_error: got %0b required 1", er); end
    checks++; if (wcnt !== 0) begin errors++; $display("FAIL err_store7_writes: got %0d required 0", wcnt); end
    issue(1'b1, 1'b0, 16'hFFFF, 16'h1111);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_wrap_error: got %0b required 1", er); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[i] !== exp_bytes[i]) begin
        errors++; $display("FAIL err_mem_byte%0d: got %h required %h", i, mem[i], exp_bytes[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b0, 16'h0006, 16'h5AA5);
    checks++; if (wcnt !== 1) begin errors++; $display("FAIL b2b_store_writes: got %0d required 1", wcnt); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_done: got %0b required 0", req_ready); end
    issue(1'b0, 1'b0, 16'h0006, 16'h0000);
    checks++; if (rd !== 16'h5AA5) begin errors++; $display("FAIL b2b_load6: got %h required 5AA5", rd); end
    issue(1'b1, 1'b1, 16'h0000, 16'h3377);
    checks++; if (wcnt !== 1) begin errors++; $display("FAIL b2b_byte_store_writes: got %0d required 1", wcnt); end
    issue(1'b0, 1'b0, 16'h0000, 16'h0000);
    checks++; if (rd !== 16'h3477) begin errors++; $display("FAIL b2b_load0: got %h required 3477", rd); end
  endtask

  initial begin
    reset = 1'b1; mem_load = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_address = 16'h0000; req_wdata = 16'h0000;
    test_reset();
    test_word_load();
    test_byte_load();
    test_misaligned_load();
    test_reset_mid();
    test_misaligned_store();
    test_errors();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
